// File: rtl/lcd_bus_receiver_if.sv
// lcd_bus_receiver_if: the 8-bit LCD bus (rs, rw, enable, data) between driver and display model.
// Master = LCD driver, slave = lcd_bus_receiver.
// With LCD_RX_READBACK_EN defined, the bus also carries the display's read-data return path.
interface lcd_bus_receiver_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_enable;
  logic [7:0] lcd_data;
`ifdef LCD_RX_READBACK_EN
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;

  modport master (output lcd_rs, lcd_rw, lcd_enable, lcd_data,
                  input  lcd_data_out, lcd_data_oe);
  modport slave  (input  lcd_rs, lcd_rw, lcd_enable, lcd_data,
                  output lcd_data_out, lcd_data_oe);
`else
  modport master (output lcd_rs, lcd_rw, lcd_enable, lcd_data);
  modport slave  (input  lcd_rs, lcd_rw, lcd_enable, lcd_data);
`endif
endinterface

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: HD44780-style display model; latches LCD bus transactions on enable fall.
// Latency: enable fall -> edge seen at clk edge 3, effects/cmd_strobe/busy register at edge 4.
// Backpressure: transactions arriving while busy are dropped with an overrun pulse.
// Optional feature macro: LCD_RX_READBACK_EN (rw=1 status/data reads on the bus).
module lcd_bus_receiver #(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic              clk,
  input  logic              reset,
  lcd_bus_receiver_if.slave bus,
  output logic              busy,
  output logic [6:0]        ac,
  output logic              cgram_sel,
  output logic              disp_on,
  output logic              cursor_on,
  output logic              blink_on,
  output logic              two_line,
  output logic              incr,
  output logic              cmd_strobe,
  output logic              overrun,
  input  logic [6:0]        rd_ddram_addr,
  output logic [7:0]        rd_ddram_data,
  input  logic [5:0]        rd_cgram_addr,
  output logic [4:0]        rd_cgram_data
);
  localparam int MAXC  = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W = $clog2(MAXC);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       clr_addr_q, clr_addr_d;
  logic             is_clr_q, is_clr_d;
  logic [6:0]       ac_q, ac_d;
  logic             cgs_q, cgs_d, disp_q, disp_d, cur_q, cur_d, blk_q, blk_d;
  logic             two_q, two_d, incr_q, incr_d, strobe_q, strobe_d, ovr_q, ovr_d;

  logic [1:0]       en_sync_q, rs_sync_q, rw_sync_q;
  logic [7:0]       dat_s1_q, dat_s2_q;
  logic             en_d_q, edge_q, rs_q, rw_q;
  logic [7:0]       data_q;

  logic [7:0]       ddram [128];
  logic [4:0]       cgram [64];
  logic             dd_we, cg_we;
  logic [6:0]       dd_waddr;
  logic [7:0]       dd_wdata;

  // Step the address counter; CGRAM addressing keeps AC[6] at 0 (modulo 64).
  function automatic logic [6:0] step_ac(input logic [6:0] a, input logic up, input logic cg);
    logic [6:0] n;
    n = up ? 7'(a + 7'd1) : 7'(a - 7'd1);
    return cg ? {1'b0, n[5:0]} : n;
  endfunction

  // Two-flop synchronisers, delayed enable, and the registered falling-edge capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_sync_q <= '0; rs_sync_q <= '0; rw_sync_q <= '0;
      dat_s1_q  <= '0; dat_s2_q  <= '0; en_d_q    <= 1'b0;
      edge_q    <= 1'b0; rs_q    <= 1'b0; rw_q    <= 1'b0; data_q <= '0;
    end else begin
      en_sync_q <= {en_sync_q[0], bus.lcd_enable};
      rs_sync_q <= {rs_sync_q[0], bus.lcd_rs};
      rw_sync_q <= {rw_sync_q[0], bus.lcd_rw};
      dat_s1_q  <= bus.lcd_data;
      dat_s2_q  <= dat_s1_q;
      en_d_q    <= en_sync_q[1];
      edge_q    <= en_d_q & ~en_sync_q[1];
      rs_q      <= rs_sync_q[1];
      rw_q      <= rw_sync_q[1];
      data_q    <= dat_s2_q;
    end
  end

  // Next state: accept/drop transactions, decode instructions, run the clear fill and busy count.
  always_comb begin
    state_d = state_q;   cnt_d = cnt_q;   clr_addr_d = clr_addr_q; is_clr_d = is_clr_q;
    ac_d    = ac_q;      cgs_d = cgs_q;   disp_d = disp_q; cur_d = cur_q; blk_d = blk_q;
    two_d   = two_q;     incr_d = incr_q; strobe_d = 1'b0; ovr_d = 1'b0;
    dd_we   = 1'b0;      cg_we = 1'b0;    dd_waddr = ac_q; dd_wdata = data_q;

    if (edge_q && state_q != S_IDLE) begin
`ifdef LCD_RX_READBACK_EN
      if (rw_q && !rs_q) strobe_d = 1'b1;
      else               ovr_d    = 1'b1;
`else
      ovr_d = 1'b1;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (edge_q) begin
          if (rw_q) begin
`ifdef LCD_RX_READBACK_EN
            strobe_d = 1'b1;
            if (rs_q) begin
              ac_d = step_ac(ac_q, incr_q, cgs_q);
              state_d = S_EXEC; cnt_d = CNT_W'(BUSY_CYCLES - 1); is_clr_d = 1'b0;
            end
`else
            ovr_d = 1'b1;
`endif
          end else begin
            strobe_d = 1'b1;
            state_d  = S_EXEC;
            cnt_d    = CNT_W'(BUSY_CYCLES - 1);
            is_clr_d = 1'b0;
            if (rs_q) begin
              dd_we = ~cgs_q;
              cg_we = cgs_q;
              ac_d  = step_ac(ac_q, incr_q, cgs_q);
            end else begin
              casez (data_q)
                8'b1???????: begin ac_d = data_q[6:0]; cgs_d = 1'b0; end
                8'b01??????: begin ac_d = {1'b0, data_q[5:0]}; cgs_d = 1'b1; end
                8'b001?????: two_d = data_q[3];
                8'b0001????: if (!data_q[3]) ac_d = step_ac(ac_q, data_q[2], cgs_q);
                8'b00001???: {disp_d, cur_d, blk_d} = data_q[2:0];
                8'b000001??: incr_d = data_q[1];
                8'b0000001?: begin
                  ac_d = '0; cgs_d = 1'b0; cnt_d = CNT_W'(CLEAR_CYCLES - 1);
                end
                8'b00000001: begin
                  ac_d = '0; cgs_d = 1'b0; incr_d = 1'b1; is_clr_d = 1'b1;
                  cnt_d = CNT_W'(CLEAR_CYCLES - 1);
                end
                default: ;
              endcase
            end
          end
        end
      end
      S_EXEC: begin
        state_d    = is_clr_q ? S_CLEAR : S_WAIT;
        cnt_d      = cnt_q - 1'b1;
        clr_addr_d = '0;
      end
      S_CLEAR: begin
        dd_we      = 1'b1;
        dd_waddr   = clr_addr_q;
        dd_wdata   = 8'h20;
        clr_addr_d = clr_addr_q + 7'd1;
        cnt_d      = cnt_q - 1'b1;
        if (clr_addr_q == 7'd127) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and display flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE; cnt_q <= '0; clr_addr_q <= '0; is_clr_q <= 1'b0;
      ac_q <= '0; cgs_q <= 1'b0; disp_q <= 1'b0; cur_q <= 1'b0; blk_q <= 1'b0;
      two_q <= 1'b0; incr_q <= 1'b1; strobe_q <= 1'b0; ovr_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; clr_addr_q <= clr_addr_d; is_clr_q <= is_clr_d;
      ac_q <= ac_d; cgs_q <= cgs_d; disp_q <= disp_d; cur_q <= cur_d; blk_q <= blk_d;
      two_q <= two_d; incr_q <= incr_d; strobe_q <= strobe_d; ovr_q <= ovr_d;
    end
  end

  // Display memories; contents are not reset, a clear instruction initialises DDRAM.
  always_ff @(posedge clk) begin
    if (dd_we) ddram[dd_waddr] <= dd_wdata;
    if (cg_we) cgram[ac_q[5:0]] <= data_q[4:0];
  end

  // Registered read ports for the renderer; a same-cycle write returns the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ddram_data <= '0;
      rd_cgram_data <= '0;
    end else begin
      rd_ddram_data <= ddram[rd_ddram_addr];
      rd_cgram_data <= cgram[rd_cgram_addr];
    end
  end

`ifdef LCD_RX_READBACK_EN
  logic [7:0] rb_q;
  // Word at AC, kept ready for a data read on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rb_q <= '0;
    else       rb_q <= cgs_q ? {3'b000, cgram[ac_q[5:0]]} : ddram[ac_q];
  end
  assign bus.lcd_data_out = rs_sync_q[1] ? rb_q : {busy, ac_q};
  assign bus.lcd_data_oe  = en_sync_q[1] & rw_sync_q[1];
`endif

  assign busy       = (state_q != S_IDLE);
  assign ac         = ac_q;
  assign cgram_sel  = cgs_q;
  assign disp_on    = disp_q;
  assign cursor_on  = cur_q;
  assign blink_on   = blk_q;
  assign two_line   = two_q;
  assign incr       = incr_q;
  assign cmd_strobe = strobe_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver: directed plus randomized bus transactions against a behavioural display model.
// Outputs are sampled on the falling clock edge; every wait on the DUT is bounded.
module tb_lcd_bus_receiver;
  localparam int BUSY  = 40;
  localparam int CLEAR = 1600;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy, cgram_sel, disp_on, cursor_on, blink_on, two_line, incr, cmd_strobe, overrun;
  logic [6:0] ac;
  logic [6:0] rd_ddram_addr;
  logic [7:0] rd_ddram_data;
  logic [5:0] rd_cgram_addr;
  logic [4:0] rd_cgram_data;

  lcd_bus_receiver_if bus_if ();

  lcd_bus_receiver #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLEAR)) dut (
    .clk(clk), .reset(reset), .bus(bus_if),
    .busy(busy), .ac(ac), .cgram_sel(cgram_sel),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .incr(incr), .cmd_strobe(cmd_strobe), .overrun(overrun),
    .rd_ddram_addr(rd_ddram_addr), .rd_ddram_data(rd_ddram_data),
    .rd_cgram_addr(rd_cgram_addr), .rd_cgram_data(rd_cgram_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the display state.
  logic [7:0] m_dd [128];
  logic [4:0] m_cg [64];
  bit         m_cgv [64];
  int         m_ac;
  bit         m_cgs, m_disp, m_cur, m_blk, m_two, m_incr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ac = 0; m_cgs = 0; m_disp = 0; m_cur = 0; m_blk = 0; m_two = 0; m_incr = 1;
  endtask

  task automatic m_move(input bit up);
    if (m_cgs) m_ac = (m_ac + (up ? 1 : 63)) % 64;
    else       m_ac = (m_ac + (up ? 1 : 127)) % 128;
  endtask

  // Apply one accepted write transaction; returns the expected busy length.
  task automatic m_apply(input bit rs, input logic [7:0] d, output int blen);
    int v;
    v = int'(d);
    blen = BUSY;
    if (rs) begin
      if (m_cgs) begin m_cg[m_ac % 64] = d[4:0]; m_cgv[m_ac % 64] = 1; end
      else       m_dd[m_ac] = d;
      m_move(m_incr);
    end else if (v >= 128) begin m_ac = v - 128; m_cgs = 0; end
    else if (v >= 64) begin m_ac = v - 64; m_cgs = 1; end
    else if (v >= 32) m_two = d[3];
    else if (v >= 16) begin if (!d[3]) m_move(d[2]); end
    else if (v >= 8) begin m_disp = d[2]; m_cur = d[1]; m_blk = d[0]; end
    else if (v >= 4) m_incr = d[1];
    else if (v >= 2) begin m_ac = 0; m_cgs = 0; blen = CLEAR; end
    else if (v == 1) begin
      for (int i = 0; i < 128; i++) m_dd[i] = 8'h20;
      m_ac = 0; m_cgs = 0; m_incr = 1; blen = CLEAR;
    end
  endtask

  function automatic logic [5:0] dut_flags();
    return {cgram_sel, disp_on, cursor_on, blink_on, two_line, incr};
  endfunction

  function automatic logic [5:0] m_flags();
    return {m_cgs, m_disp, m_cur, m_blk, m_two, m_incr};
  endfunction

  // One enable pulse. accept: the model expects it taken; wait_done: follow busy to completion.
  task automatic xact(input string tag, input bit rs, input bit rw, input logic [7:0] d,
                      input bit accept, input bit wait_done);
    int exp_len, lat, blen, ns, no, k;
    bit done;
    exp_len = 0; lat = 0; blen = 0; ns = 0; no = 0; done = 0;
    if (accept) m_apply(rs, d, exp_len);
    @(negedge clk);
    bus_if.lcd_rs = rs; bus_if.lcd_rw = rw; bus_if.lcd_data = d; bus_if.lcd_enable = 1'b1;
    repeat (4) @(negedge clk);
    bus_if.lcd_enable = 1'b0;
    for (k = 1; k <= 3000 && !done; k++) begin
      @(negedge clk);
      if (cmd_strobe && lat == 0) lat = k;
      ns += int'(cmd_strobe);
      no += int'(overrun);
      if (busy) blen++;
      if (!wait_done && k == 6) done = 1;
      if (wait_done && k >= 6 && !busy) done = 1;
    end
    if (!done) chk({tag, " timeout"}, 32'(k), 32'd0);
    if (accept) begin
      chk({tag, " strobes"}, 32'(ns), 32'd1);
      chk({tag, " latency"}, 32'(lat), 32'd4);
      chk({tag, " overrun"}, 32'(no), 32'd0);
      if (wait_done) chk({tag, " busy_len"}, 32'(blen), 32'(exp_len));
    end else begin
      chk({tag, " strobes"}, 32'(ns), 32'd0);
      chk({tag, " overrun"}, 32'(no), 32'd1);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 3000) begin @(negedge clk); k++; end
    chk({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  task automatic rd_dd(input int a, output logic [7:0] v);
    @(negedge clk); rd_ddram_addr = 7'(a);
    @(negedge clk); v = rd_ddram_data;
  endtask

  task automatic rd_cg(input int a, output logic [4:0] v);
    @(negedge clk); rd_cgram_addr = 6'(a);
    @(negedge clk); v = rd_cgram_data;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, " ac"}, 32'(ac), 32'(m_ac));
    chk({tag, " flags"}, 32'(dut_flags()), 32'(m_flags()));
  endtask

  initial begin
    logic [7:0] v8;
    logic [4:0] v5;
    logic [7:0] d;
    bus_if.lcd_rs = 0; bus_if.lcd_rw = 0; bus_if.lcd_enable = 0; bus_if.lcd_data = 0;
    rd_ddram_addr = 0; rd_cgram_addr = 0;
    for (int i = 0; i < 64; i++) m_cgv[i] = 0;
    for (int i = 0; i < 128; i++) m_dd[i] = 8'h00;
    m_reset();

    // Reset state.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst strobe_ovr", 32'({cmd_strobe, overrun}), 32'd0);
    chk("rst rd_data", 32'({rd_ddram_data, rd_cgram_data}), 32'd0);
    chk_state("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Initialisation sequence.
    xact("fset", 0, 0, 8'h38, 1, 1);
    xact("dctl", 0, 0, 8'h0C, 1, 1);
    xact("entry", 0, 0, 8'h06, 1, 1);
    chk_state("init");

    // Clear fills DDRAM with spaces.
    xact("clear", 0, 0, 8'h01, 1, 1);
    chk_state("clear");
    for (int i = 0; i < 128; i++) begin
      rd_dd(i, v8);
      chk("clear dd", 32'(v8), 32'(m_dd[i]));
    end

    // CGRAM writes.
    xact("cgaddr", 0, 0, 8'h40, 1, 1);
    xact("cg0", 1, 0, 8'h1F, 1, 1);
    xact("cg1", 1, 0, 8'h11, 1, 1);
    chk_state("cg");
    rd_cg(0, v5); chk("cgram0", 32'(v5), 32'h1F);
    rd_cg(1, v5); chk("cgram1", 32'(v5), 32'h11);

    // DDRAM write, then a second write during busy is dropped.
    xact("ddaddr", 0, 0, 8'hC4, 1, 1);
    xact("dd44", 1, 0, 8'h03, 1, 0);
    xact("ddovr", 1, 0, 8'h77, 0, 0);
    wait_idle("ddovr");
    chk_state("ddovr");
    rd_dd(8'h44, v8); chk("dd44 data", 32'(v8), 32'h03);
    rd_dd(8'h45, v8); chk("dd45 kept", 32'(v8), 32'h20);

    // AC wrap in both directions.
    xact("ac7f", 0, 0, 8'hFF, 1, 1);
    xact("wrap_up", 1, 0, 8'h41, 1, 1);
    chk_state("wrap_up");
    xact("decr", 0, 0, 8'h04, 1, 1);
    xact("wrap_dn", 1, 0, 8'h42, 1, 1);
    chk_state("wrap_dn");

    // Read transaction without readback support is dropped.
    xact("rw1", 0, 1, 8'h00, 0, 0);
    chk_state("rw1");

    // Randomized instructions and data.
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 6) xact("rnd data", 1, 0, d, 1, 1);
      else                          xact("rnd instr", 0, 0, d, 1, 1);
      chk_state("rnd");
    end
    for (int i = 0; i < 128; i++) begin
      rd_dd(i, v8);
      chk("rnd dd", 32'(v8), 32'(m_dd[i]));
    end
    for (int i = 0; i < 64; i++) begin
      if (m_cgv[i]) begin
        rd_cg(i, v5);
        chk("rnd cg", 32'(v5), 32'(m_cg[i]));
      end
    end

    // Reset in the middle of the clear fill.
    xact("clr_abort", 0, 0, 8'h01, 1, 0);
    repeat (50) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    m_reset();
    chk_state("abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    xact("post_abort", 0, 0, 8'h85, 1, 1);
    chk_state("post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
